// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: trigger pulse, synchronized echo timing in us, timeout and re-trigger holdoff.
// Optional feature macro ULTRASONIC_RANGER_DIST_CM_EN adds dist_cm = (echo count * 1130) >> 16.
module ultrasonic_ranger #(
  parameter int CLK_HZ     = 50000000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000,
  parameter int WIDTH      = 16,
  parameter int THRESH_US  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             auto_en,
  input  logic             Echo,
  output logic             Trigger,
  output logic [WIDTH-1:0] echo_us,
  output logic             valid,
  output logic             timeout,
  output logic             near,
  output logic             busy
`ifdef ULTRASONIC_RANGER_DIST_CM_EN
  ,
  output logic [WIDTH-1:0] dist_cm
`endif
);
  localparam int DIV      = CLK_HZ / 1000000;
  localparam int PER_CLKS = PERIOD_US * DIV;
  localparam int TMAX     = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW       = $clog2(TMAX + 1);
  localparam int PW       = $clog2(PER_CLKS + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [32:0]      THRESH_L = 33'(THRESH_US);

  typedef enum logic [2:0] {ST_IDLE, ST_TRIG, ST_WAIT, ST_MEAS, ST_HOLD} state_t;

  state_t            state_q, state_d;
  logic              echo_s1_q, echo_s2_q;
  logic              seen_low_q, seen_low_d;
  logic [DW-1:0]     presc_q, presc_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [PW-1:0]     per_q, per_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic              trig_q, valid_q, timeout_q, near_q;
  logic [WIDTH-1:0]  echo_us_q;
  logic              tick, fin_ok, fin_to;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == ALL_ONES) ? v : v + WIDTH'(1);
  endfunction

  assign tick = (presc_q == DW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    fin_ok  = 1'b0;
    fin_to  = 1'b0;
    case (state_q)
      ST_IDLE: if (start || auto_en) state_d = ST_TRIG;
      ST_TRIG: if (tick && tmr_q == TW'(TRIG_US - 1)) state_d = ST_WAIT;
      // A rise only counts once the synchronized echo has been seen low in this state
      ST_WAIT: begin
        if (echo_s2_q && seen_low_q) begin
          state_d = ST_MEAS;
        end else if (tick && tmr_q == TW'(TIMEOUT_US - 1)) begin
          fin_to  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_MEAS: begin
        if (!echo_s2_q) begin
          fin_ok  = 1'b1;
          state_d = ST_HOLD;
        end else if (tick && tmr_q == TW'(TIMEOUT_US - 1)) begin
          fin_to  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      // Exit two clocks early: one cycle in IDLE, then TRIG lands exactly on the period
      ST_HOLD: if (per_q >= PW'(PER_CLKS - 2)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + DW'(1);
    if ((state_d == ST_TRIG || state_d == ST_MEAS) && state_d != state_q) presc_d = '0;
    tmr_d = (state_d != state_q) ? '0 : (tick ? tmr_q + TW'(1) : tmr_q);
    per_d = (per_q == PW'(PER_CLKS)) ? per_q : per_q + PW'(1);
    if (state_d == ST_TRIG && state_q != ST_TRIG) per_d = '0;
    seen_low_d = (state_q == ST_WAIT) && (seen_low_q || !echo_s2_q);
    cnt_d = cnt_q;
    if (state_d == ST_MEAS && state_q != ST_MEAS) cnt_d = '0;
    else if (state_q == ST_MEAS && tick && echo_s2_q) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      echo_s1_q  <= 1'b0;
      echo_s2_q  <= 1'b0;
      seen_low_q <= 1'b0;
      presc_q    <= '0;
      tmr_q      <= '0;
      per_q      <= '0;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      near_q     <= 1'b0;
      echo_us_q  <= '0;
    end else begin
      state_q    <= state_d;
      echo_s1_q  <= Echo;
      echo_s2_q  <= echo_s1_q;
      seen_low_q <= seen_low_d;
      presc_q    <= presc_d;
      tmr_q      <= tmr_d;
      per_q      <= per_d;
      cnt_q      <= cnt_d;
      trig_q     <= (state_d == ST_TRIG);
      valid_q    <= fin_ok || fin_to;
      if (fin_to) begin
        echo_us_q <= ALL_ONES;
        timeout_q <= 1'b1;
        near_q    <= 1'b0;
      end else if (fin_ok) begin
        echo_us_q <= cnt_q;
        timeout_q <= 1'b0;
        near_q    <= (33'(cnt_q) < THRESH_L);
      end
    end
  end

`ifdef ULTRASONIC_RANGER_DIST_CM_EN
  logic [WIDTH+10:0] prod;
  logic [WIDTH-1:0]  dist_q;

  // 1130/65536 approximates 1/58 (us of round trip per cm)
  assign prod = (WIDTH+11)'(cnt_q) * (WIDTH+11)'(1130);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dist_q <= '0;
    else if (fin_to) dist_q <= ALL_ONES;
    else if (fin_ok) dist_q <= WIDTH'(prod >> 16);
  end

  assign dist_cm = dist_q;
`endif

  assign Trigger = trig_q;
  assign echo_us = echo_us_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign near    = near_q;
  assign busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed/randomized bench for ultrasonic_ranger against a us-level reference of the ranging rules.
module tb_ultrasonic_ranger;
  localparam int CLK_HZ = 2000000;
  localparam int DIV    = CLK_HZ / 1000000;
  localparam int TRIG_US = 10;
  localparam int TO_US   = 300;
  localparam int PER_US  = 600;
  localparam int TH_US   = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, auto0 = 1'b0, echo0 = 1'b0;
  logic start1 = 1'b0, echo1 = 1'b0;
  logic trig0, valid0, to0, near0, busy0;
  logic trig1, valid1, to1, near1, busy1;
  logic [15:0] eu0;
  logic [7:0]  eu1;
`ifdef ULTRASONIC_RANGER_DIST_CM_EN
  logic start2 = 1'b0, echo2 = 1'b0;
  logic trig2, valid2, to2, near2, busy2;
  logic [15:0] eu2, dist0, dist2;
  logic [7:0]  dist1;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ultrasonic_ranger #(.CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .TIMEOUT_US(TO_US), .PERIOD_US(PER_US),
                      .WIDTH(16), .THRESH_US(TH_US)) u0 (
    .clk(clk), .rst(rst), .start(start0), .auto_en(auto0), .Echo(echo0), .Trigger(trig0),
    .echo_us(eu0), .valid(valid0), .timeout(to0), .near(near0), .busy(busy0)
`ifdef ULTRASONIC_RANGER_DIST_CM_EN
    , .dist_cm(dist0)
`endif
  );

  ultrasonic_ranger #(.CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .TIMEOUT_US(TO_US), .PERIOD_US(PER_US),
                      .WIDTH(8), .THRESH_US(TH_US)) u1 (
    .clk(clk), .rst(rst), .start(start1), .auto_en(1'b0), .Echo(echo1), .Trigger(trig1),
    .echo_us(eu1), .valid(valid1), .timeout(to1), .near(near1), .busy(busy1)
`ifdef ULTRASONIC_RANGER_DIST_CM_EN
    , .dist_cm(dist1)
`endif
  );

`ifdef ULTRASONIC_RANGER_DIST_CM_EN
  ultrasonic_ranger #(.CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .TIMEOUT_US(2000), .PERIOD_US(4000),
                      .WIDTH(16), .THRESH_US(TH_US)) u2 (
    .clk(clk), .rst(rst), .start(start2), .auto_en(1'b0), .Echo(echo2), .Trigger(trig2),
    .echo_us(eu2), .valid(valid2), .timeout(to2), .near(near2), .busy(busy2), .dist_cm(dist2)
  );
`endif

  // Event log of the main instance, sampled on rising edges
  int cyc = 0, tlen = 0, last_tlen = 0, vcnt = 0, busy_fall = 0;
  int rises[$];
  logic trig_d = 1'b0, busy_d = 1'b0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    trig_d <= trig0;
    busy_d <= busy0;
    if (trig0 && !trig_d) begin
      rises.push_back(cyc);
      tlen <= 1;
    end else if (trig0) begin
      tlen <= tlen + 1;
    end
    if (!trig0 && trig_d) last_tlen <= tlen;
    if (valid0) vcnt <= vcnt + 1;
    if (busy_d && !busy0) busy_fall <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic trig_of(input int w);
    if (w == 0) return trig0;
    if (w == 1) return trig1;
`ifdef ULTRASONIC_RANGER_DIST_CM_EN
    if (w == 2) return trig2;
`endif
    return 1'b0;
  endfunction

  function automatic logic valid_of(input int w);
    if (w == 0) return valid0;
    if (w == 1) return valid1;
`ifdef ULTRASONIC_RANGER_DIST_CM_EN
    if (w == 2) return valid2;
`endif
    return 1'b0;
  endfunction

  function automatic logic busy_of(input int w);
    if (w == 0) return busy0;
    if (w == 1) return busy1;
`ifdef ULTRASONIC_RANGER_DIST_CM_EN
    if (w == 2) return busy2;
`endif
    return 1'b0;
  endfunction

  task automatic set_in(input int w, input logic st, input logic ec);
    if (w == 0) begin start0 = st; echo0 = ec; end
    if (w == 1) begin start1 = st; echo1 = ec; end
`ifdef ULTRASONIC_RANGER_DIST_CM_EN
    if (w == 2) begin start2 = st; echo2 = ec; end
`endif
  endtask

  task automatic capture(input int w, output logic [15:0] e, output logic to, output logic nr);
    e = eu0; to = to0; nr = near0;
    if (w == 1) begin e = {8'h00, eu1}; to = to1; nr = near1; end
`ifdef ULTRASONIC_RANGER_DIST_CM_EN
    if (w == 2) begin e = eu2; to = to2; nr = near2; end
`endif
  endtask

  // One measurement: optional start, wait out the trigger, then Echo high for w_us
  // beginning d_us after Trigger falls. vk = clocks from Trigger fall to valid.
  task automatic run_meas(input int w, input bit do_start, input int d_us, input int w_us,
                          output int vk, output logic [15:0] e, output logic to,
                          output logic nr, output bit ok);
    int n;
    bit got;
    ok = 1'b0; got = 1'b0; vk = -1; e = '0; to = 1'b0; nr = 1'b0; n = 0;
    if (do_start) begin
      set_in(w, 1'b1, 1'b0);
      @(negedge clk);
      set_in(w, 1'b0, 1'b0);
    end
    while (!trig_of(w) && n < 20000) begin @(negedge clk); n++; end
    while (trig_of(w) && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) return;
    for (int k = 0; k < 12000; k++) begin
      set_in(w, 1'b0, (k >= DIV * d_us) && (k < DIV * (d_us + w_us)));
      if (!got && valid_of(w)) begin
        got = 1'b1;
        vk  = k;
        capture(w, e, to, nr);
      end
      if (got && k >= DIV * (d_us + w_us)) break;
      @(negedge clk);
    end
    set_in(w, 1'b0, 1'b0);
    ok = got;
  endtask

  task automatic wait_idle(input int w, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_of(w)) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    int vk, d, wd, nb, v0, n;
    logic [15:0] e;
    logic to, nr;
    bit ok;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_main", {trig0, valid0, to0, near0, busy0, eu0}, 0);
    chk("reset_w8", {trig1, valid1, to1, near1, busy1, eu1}, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single shot, 150 us echo 50 us after trigger
    v0 = vcnt;
    run_meas(0, 1'b1, 50, 150, vk, e, to, nr, ok);
    chk("ss_valid_seen", ok, 1);
    chk("ss_trig_len", last_tlen, TRIG_US * DIV);
    chk_rng("ss_echo_us", e, 149, 151);
    chk("ss_timeout", to, 0);
    chk("ss_near", nr, 0);
    chk("ss_busy_holdoff", busy0, 1);
    nb = rises.size();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0, 3000, ok);
    chk("ss_idle_reached", ok, 1);
    repeat (2) @(negedge clk);
    chk_rng("ss_busy_drop", busy_fall - rises[nb-1], PER_US * DIV - 1, PER_US * DIV);
    chk("ss_one_valid", vcnt - v0, 1);
    repeat (1500) @(negedge clk);
    chk("ss_start_busy_ignored", rises.size(), nb);

    // Near case then random widths, avoiding the threshold's +-1 ambiguity
    for (int i = 0; i < 4; i++) begin
      d  = $urandom_range(5, 80);
      wd = (i == 0) ? 40 : $urandom_range(10, 290);
      if (wd >= TH_US - 2 && wd <= TH_US + 2) wd = 150;
      run_meas(0, 1'b1, d, wd, vk, e, to, nr, ok);
      chk("rnd_valid_seen", ok, 1);
      chk_rng("rnd_echo_us", e, wd - 1, wd + 1);
      chk("rnd_near", nr, (wd < TH_US));
      chk("rnd_timeout", to, 0);
      wait_idle(0, 3000, ok);
      chk("rnd_idle", ok, 1);
    end

    // WIDTH=8 saturation
    run_meas(1, 1'b1, 10, 280, vk, e, to, nr, ok);
    chk("w8_valid_seen", ok, 1);
    chk("w8_echo_sat", e, 255);
    chk("w8_timeout", to, 0);
    wait_idle(1, 3000, ok);
    chk("w8_idle", ok, 1);

    // No echo: timeout exactly TIMEOUT_US after Trigger falls
    run_meas(0, 1'b1, 0, 0, vk, e, to, nr, ok);
    chk("noecho_valid_seen", ok, 1);
    chk("noecho_valid_time", vk, TO_US * DIV);
    chk("noecho_timeout", to, 1);
    chk("noecho_echo_us", e, 16'hFFFF);
    chk("noecho_near", nr, 0);
    wait_idle(0, 3000, ok);

    // Echo stuck high 400 us: timeout TIMEOUT_US into the measurement (plus sync latency)
    run_meas(0, 1'b1, 20, 400, vk, e, to, nr, ok);
    chk("stuck_valid_seen", ok, 1);
    chk_rng("stuck_valid_time", vk, DIV * (20 + TO_US), DIV * (20 + TO_US) + 6);
    chk("stuck_timeout", to, 1);
    chk("stuck_echo_us", e, 16'hFFFF);
    wait_idle(0, 3000, ok);

    // Free-running: three measurements, then auto_en drops and the FSM parks
    nb = rises.size();
    auto0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_meas(0, 1'b0, 20, 100, vk, e, to, nr, ok);
      chk_rng("auto_echo_us", e, 99, 101);
    end
    auto0 = 1'b0;
    wait_idle(0, 3000, ok);
    repeat (1500) @(negedge clk);
    chk("auto_rise_count", rises.size() - nb, 3);
    if (rises.size() >= nb + 3) begin
      chk("auto_spacing_1", rises[nb+1] - rises[nb], PER_US * DIV);
      chk("auto_spacing_2", rises[nb+2] - rises[nb+1], PER_US * DIV);
    end

    // Asynchronous reset in the middle of MEASURE
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!trig0 && n < 3000) begin @(negedge clk); n++; end
    while (trig0 && n < 3000) begin @(negedge clk); n++; end
    chk("rst_trigger_seen", (n < 3000), 1);
    repeat (20) @(negedge clk);
    echo0 = 1'b1;
    repeat (100) @(negedge clk);
    v0 = vcnt;
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outs", {trig0, valid0, to0, near0, busy0, eu0}, 0);
    repeat (3) @(negedge clk);
    echo0 = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_valid", vcnt - v0, 0);
    run_meas(0, 1'b1, 30, 70, vk, e, to, nr, ok);
    chk("rst_fresh_valid", ok, 1);
    chk_rng("rst_fresh_echo", e, 69, 71);
    chk("rst_fresh_near", nr, 1);
    chk("rst_fresh_timeout", to, 0);
    wait_idle(0, 3000, ok);

`ifdef ULTRASONIC_RANGER_DIST_CM_EN
    chk("dist_main_hold", dist0, (32'(eu0) * 1130) >> 16);
    chk("dist_w8_hold", dist1, (32'(eu1) * 1130) >> 16);
    run_meas(2, 1'b1, 10, 581, vk, e, to, nr, ok);
    chk_rng("dist_580_echo", e, 580, 582);
    chk("dist_580_cm", dist2, (32'(e) * 1130) >> 16);
    wait_idle(2, 10000, ok);
    run_meas(2, 1'b1, 10, 1161, vk, e, to, nr, ok);
    chk_rng("dist_1160_echo", e, 1160, 1162);
    chk("dist_1160_cm", dist2, (32'(e) * 1130) >> 16);
    wait_idle(2, 10000, ok);
    run_meas(2, 1'b1, 0, 0, vk, e, to, nr, ok);
    chk("dist_to_flag", to, 1);
    chk("dist_to_cm", dist2, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
